// File: rtl/ex_stage_mc.sv
// Execute stage with a multi-cycle MAC path and a single output holding register.
// A non-MAC result appears one cycle after transfer. A MAC result appears MAC_LAT cycles after transfer.
module ex_stage_mc #(
   parameter int XLEN    = 32,
   parameter int MAC_LAT = 3,
   parameter int OP_W    = 4
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [XLEN-1:0] op_1,
   input  logic [XLEN-1:0] op_2,
   input  logic [XLEN-1:0] op_3,
   input  logic [XLEN-1:0] mem_offset,
   input  logic [OP_W-1:0] alu_op,
   input  logic [4:0]      rd_addr,
   input  logic            rd_we,
   input  logic [31:0]     inst,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [4:0]      rd_addr_wb,
   output logic            rd_we_wb,
   output logic [XLEN-1:0] rd_data,
   output logic [XLEN-1:0] mem_addr_mem,
   output logic [OP_W-1:0] alu_op_mem,
   output logic [XLEN-1:0] op_2_mem,
   output logic [31:0]     ex_inst,
   output logic            busy
);

   localparam int SH_W = $clog2(XLEN);
   localparam logic [OP_W-1:0] OP_ADD = OP_W'(0);
   localparam logic [OP_W-1:0] OP_SUB = OP_W'(1);
   localparam logic [OP_W-1:0] OP_AND = OP_W'(2);
   localparam logic [OP_W-1:0] OP_OR  = OP_W'(3);
   localparam logic [OP_W-1:0] OP_SLL = OP_W'(4);
   localparam logic [OP_W-1:0] OP_SRA = OP_W'(5);
   localparam logic [OP_W-1:0] OP_SW  = OP_W'(6);
   localparam logic [OP_W-1:0] OP_LW  = OP_W'(7);
   localparam logic [OP_W-1:0] OP_MAC = OP_W'(8);
   localparam bit MULTI = (MAC_LAT > 1);

   typedef enum logic {S_IDLE, S_MAC} state_t;

   state_t state_q, state_d;
   logic [3:0]      cnt_q, cnt_d;
   logic            out_valid_q, out_valid_d;
   logic [4:0]      rd_addr_q, rd_addr_d;
   logic            rd_we_q, rd_we_d;
   logic [XLEN-1:0] rd_data_q, rd_data_d;
   logic [XLEN-1:0] mem_addr_q, mem_addr_d;
   logic [OP_W-1:0] alu_op_q, alu_op_d;
   logic [XLEN-1:0] op_2_q, op_2_d;
   logic [31:0]     inst_q, inst_d;
   logic [XLEN-1:0] mac_a_q, mac_a_d, mac_b_q, mac_b_d, mac_c_q, mac_c_d;

   logic in_ready_c, busy_c;
   logic accept, is_mac, mac_start, mac_done;

   function automatic logic op_defined(input logic [OP_W-1:0] op);
      case (op)
         OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLL, OP_SRA, OP_SW, OP_LW, OP_MAC: op_defined = 1'b1;
         default: op_defined = 1'b0;
      endcase
   endfunction

   function automatic logic [XLEN-1:0] alu_result(input logic [OP_W-1:0] op,
                                                  input logic [XLEN-1:0] a, b, c);
      logic signed [XLEN-1:0] a_s;
      a_s = a;
      case (op)
         OP_ADD:  alu_result = a + b;
         OP_SUB:  alu_result = a - b;
         OP_AND:  alu_result = a & b;
         OP_OR:   alu_result = a | b;
         OP_SLL:  alu_result = a << b[SH_W-1:0];
         OP_SRA:  alu_result = a_s >>> b[SH_W-1:0];
         OP_MAC:  alu_result = a * b + c;
         default: alu_result = '0;
      endcase
   endfunction

   assign accept    = in_valid && in_ready_c;
   assign is_mac    = (alu_op == OP_MAC);
   assign mac_start = accept && is_mac && MULTI;
   // The result is loaded on the edge where the counter steps from 1 to 0.
   assign mac_done  = (state_q == S_MAC) && (cnt_q == 4'd1) && !flush;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         out_valid_q <= 1'b0;
         rd_addr_q   <= '0;
         rd_we_q     <= 1'b0;
         rd_data_q   <= '0;
         mem_addr_q  <= '0;
         alu_op_q    <= '0;
         op_2_q      <= '0;
         inst_q      <= '0;
         mac_a_q     <= '0;
         mac_b_q     <= '0;
         mac_c_q     <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         out_valid_q <= out_valid_d;
         rd_addr_q   <= rd_addr_d;
         rd_we_q     <= rd_we_d;
         rd_data_q   <= rd_data_d;
         mem_addr_q  <= mem_addr_d;
         alu_op_q    <= alu_op_d;
         op_2_q      <= op_2_d;
         inst_q      <= inst_d;
         mac_a_q     <= mac_a_d;
         mac_b_q     <= mac_b_d;
         mac_c_q     <= mac_c_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (flush) begin
         state_d = S_IDLE;
         cnt_d   = '0;
      end else if (mac_start) begin
         state_d = S_MAC;
         cnt_d   = 4'(MAC_LAT - 1);
      end else if (state_q == S_MAC) begin
         cnt_d = cnt_q - 4'd1;
         if (cnt_q == 4'd1) state_d = S_IDLE;
      end
   end

   always_comb begin
      busy_c     = (state_q == S_MAC);
      in_ready_c = (state_q == S_IDLE) && (!out_valid_q || out_ready) && !flush;
   end

   always_comb begin
      rd_addr_d   = rd_addr_q;
      rd_we_d     = rd_we_q;
      rd_data_d   = rd_data_q;
      mem_addr_d  = mem_addr_q;
      alu_op_d    = alu_op_q;
      op_2_d      = op_2_q;
      inst_d      = inst_q;
      mac_a_d     = mac_a_q;
      mac_b_d     = mac_b_q;
      mac_c_d     = mac_c_q;
      out_valid_d = out_valid_q;

      // Metadata is taken at transfer. The output is empty or draining then, so this is safe for MAC too.
      if (accept) begin
         rd_addr_d  = rd_addr;
         rd_we_d    = rd_we && op_defined(alu_op);
         alu_op_d   = alu_op;
         op_2_d     = op_2;
         inst_d     = inst;
         mem_addr_d = (alu_op == OP_SW || alu_op == OP_LW) ? op_1 + mem_offset : '0;
         if (!mac_start) rd_data_d = alu_result(alu_op, op_1, op_2, op_3);
      end
      if (mac_start) begin
         mac_a_d = op_1;
         mac_b_d = op_2;
         mac_c_d = op_3;
      end
      if (mac_done) rd_data_d = mac_a_q * mac_b_q + mac_c_q;

      if (flush)                         out_valid_d = 1'b0;
      else if (accept && !mac_start)     out_valid_d = 1'b1;
      else if (mac_done)                 out_valid_d = 1'b1;
      else if (out_ready)                out_valid_d = 1'b0;
   end

   assign in_ready     = in_ready_c;
   assign busy         = busy_c;
   assign out_valid    = out_valid_q;
   assign rd_addr_wb   = rd_addr_q;
   assign rd_we_wb     = rd_we_q;
   assign rd_data      = rd_data_q;
   assign mem_addr_mem = mem_addr_q;
   assign alu_op_mem   = alu_op_q;
   assign op_2_mem     = op_2_q;
   assign ex_inst      = inst_q;

endmodule

// File: doc/ex_stage_mc.md
EX_STAGE_MC -- requirements
Module: ex_stage_mc

Interface
REQ-001 The block SHALL expose parameter XLEN, default 32, meaning datapath width in bits (legal: 32, 64).
REQ-002 The block SHALL expose parameter MAC_LAT, default 3, meaning MAC cycles from accept to result (legal: 1..15).
REQ-003 The block SHALL expose parameter OP_W, default 4, meaning alu_op width.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 reset  input  1  reset, synchronous, active-high.
REQ-006 flush  input  1  discard in-flight and held operation.
REQ-007 in_valid, in_ready  input/output  1 each  upstream handshake.
REQ-008 op_1, op_2, op_3, mem_offset  input  XLEN each  operands and memory offset.
REQ-009 alu_op  input  OP_W  operation, encodings per project define header (ADD, SUB, AND, OR, SLL, SRA, SW, LW, MAC).
REQ-010 rd_addr, rd_we, inst  input  5/1/32  destination, write enable, instruction word.
REQ-011 out_valid, out_ready  output/input  1 each  downstream handshake.
REQ-012 rd_addr_wb, rd_we_wb, rd_data, mem_addr_mem  output  5/1/XLEN/XLEN  registered results.
REQ-013 alu_op_mem, op_2_mem, ex_inst  output  OP_W/XLEN/32  registered pass-through.
REQ-014 busy  output  1  high while in MAC state.

Function
REQ-015 The block SHALL have states IDLE, MAC and one output holding register gated by out_valid.
REQ-016 in_ready SHALL equal (state==IDLE) && (!out_valid || out_ready) && !flush.
REQ-017 Transfer SHALL occur on a cycle with in_valid && in_ready; operands and metadata are captured there.
REQ-018 Non-MAC ops SHALL produce out_valid=1 with result on the cycle after transfer (latency 1).
REQ-019 ADD/SUB/AND/OR SHALL compute op_1 op op_2 modulo 2^XLEN.
REQ-020 SLL/SRA SHALL shift op_1 by op_2[log2(XLEN)-1:0]; SRA sign-fills.
REQ-021 SW/LW SHALL set mem_addr_mem = op_1 + mem_offset (mod 2^XLEN), rd_data = 0; other ops set mem_addr_mem = 0.
REQ-022 MAC SHALL move IDLE->MAC, load a down-counter with MAC_LAT-1, and set rd_data = low XLEN bits of op_1*op_2 + op_3 when the counter reaches 0.
REQ-023 MAC->IDLE SHALL occur the cycle the result is loaded; out_valid rises that cycle edge, so total latency is MAC_LAT cycles; MAC_LAT=1 behaves as latency 1.
REQ-024 Undefined alu_op SHALL complete in 1 cycle with rd_data = 0, mem_addr_mem = 0, rd_we_wb forced 0.
REQ-025 rd_addr_wb, rd_we_wb, alu_op_mem, op_2_mem, ex_inst SHALL be the captured values of the transferring op.
REQ-026 All outputs SHALL stay stable while out_valid && !out_ready.
REQ-027 out_valid SHALL clear after out_valid && out_ready unless a new op completes the same edge (back-to-back, one result per cycle for non-MAC ops).
REQ-028 flush SHALL, on the next edge, clear out_valid, return state to IDLE and cancel the counter; a concurrent in_valid is not accepted.
REQ-029 in_ready SHALL be 0 throughout MAC; busy = 1 exactly while state==MAC.

Reset
REQ-030 On reset, state SHALL be IDLE, counter 0, out_valid 0, busy 0, and rd_addr_wb, rd_we_wb, rd_data, mem_addr_mem, alu_op_mem, op_2_mem, ex_inst all 0.
REQ-031 Reset SHALL take priority over flush and handshakes, including mid-MAC; in_ready is 1 the first cycle after reset deasserts.

Verification
REQ-032 ADD op_1=5, op_2=7, rd_addr=3, rd_we=1, out_ready=1 -> next cycle out_valid=1, rd_data=12, rd_addr_wb=3, rd_we_wb=1.
REQ-033 SRA op_1=0x80000000, op_2=0x24 (XLEN=32) -> rd_data=0xF8000000; LW op_1=0x100, mem_offset=0xFFFFFFFC -> mem_addr_mem=0xFC, rd_data=0.
REQ-034 MAC op_1=3, op_2=4, op_3=10, MAC_LAT=3 -> busy=1 and in_ready=0 for cycles 1-2, out_valid=1 with rd_data=22 at cycle 3.
REQ-035 out_ready=0 for 4 cycles after ADD result -> outputs constant, in_ready=0; releasing out_ready with new in_valid -> next result the following cycle.
REQ-036 reset or flush asserted at MAC cycle 1 -> next cycle state IDLE, out_valid=0, busy=0, no result emitted.
REQ-037 Undefined alu_op with rd_we=1 -> out_valid=1, rd_we_wb=0, rd_data=0.
